logic_unit_pipe: RTL and testbench

//  Parametrised, pipelined bitwise logic unit; next generation of the 64-bit XOR datapath.

---
 rtl/logic_unit_pkg.sv | 17 +
 rtl/logic_unit_stage.sv | 39 +++
 rtl/logic_unit_pipe.sv | 108 ++++++++++
 tb/tb_logic_unit_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared opcode encoding and widths for the pipelined bitwise logic unit.
package logic_unit_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_PASS = 3'd7
  } op_e;

endpackage

// File: rtl/logic_unit_stage.sv
// One pipeline slice holding {valid, result, zero, parity}.
// Loads whenever empty or when the downstream slice is taking its contents.
module logic_unit_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_r,
  input  logic             in_zero,
  input  logic             in_par,
  input  logic             adv,
  output logic             en,
  output logic             valid,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             par
);

  assign en = ~valid | adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      r     <= '0;
      zero  <= 1'b0;
      par   <= 1'b0;
    end else if (en) begin
      valid <= in_valid;
      // Bubbles leave the old payload in place so out_r only moves on real data.
      if (in_valid) begin
        r    <= in_r;
        zero <= in_zero;
        par  <= in_par;
      end
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: op decode and flags up front, LATENCY slices
// behind it, valid/ready on both sides with a combinational ready chain.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic             out_zero,
  output logic             out_par
);

  if ((WIDTH < 1) || (LATENCY < 1) || (LATENCY > 4)) begin : g_param_check
    $error("logic_unit_pipe: WIDTH must be >=1 and LATENCY must be 1..4");
  end

  logic [WIDTH-1:0] res;
  logic             res_zero;
  logic             res_par;

  always_comb begin
    res = '0;
    case (op_e'(in_op))
      OP_AND:  res = in_a & in_b;
      OP_OR:   res = in_a | in_b;
      OP_XOR:  res = in_a ^ in_b;
      OP_NAND: res = ~(in_a & in_b);
      OP_NOR:  res = ~(in_a | in_b);
      OP_XNOR: res = ~(in_a ^ in_b);
      OP_NOTA: res = ~in_a;
      OP_PASS: res = in_a;
      default: res = in_a;
    endcase
  end

  assign res_zero = ~|res;
  assign res_par  = ^res;

  logic [LATENCY-1:0] v;
  logic [LATENCY-1:0] en;
  logic [LATENCY-1:0] adv;
  logic [WIDTH-1:0]   r_q [LATENCY];
  logic [LATENCY-1:0] zero_q;
  logic [LATENCY-1:0] par_q;

  // adv[k] = en[k+1], unrolled from the tail: a slice may pass its contents on
  // if the output is taken or any later slice has a hole.
  always_comb begin
    logic room;
    adv  = '0;
    room = out_ready;
    for (int k = LATENCY - 1; k >= 0; k--) begin
      adv[k] = room;
      room   = room | ~v[k];
    end
  end

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    logic             ld_valid;
    logic [WIDTH-1:0] ld_r;
    logic             ld_zero;
    logic             ld_par;

    if (k == 0) begin : g_head
      assign ld_valid = in_valid;
      assign ld_r     = res;
      assign ld_zero  = res_zero;
      assign ld_par   = res_par;
    end else begin : g_body
      assign ld_valid = v[k-1];
      assign ld_r     = r_q[k-1];
      assign ld_zero  = zero_q[k-1];
      assign ld_par   = par_q[k-1];
    end

    logic_unit_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (ld_valid),
      .in_r     (ld_r),
      .in_zero  (ld_zero),
      .in_par   (ld_par),
      .adv      (adv[k]),
      .en       (en[k]),
      .valid    (v[k]),
      .r        (r_q[k]),
      .zero     (zero_q[k]),
      .par      (par_q[k])
    );
  end

  assign in_ready  = en[0] & ~rst;
  assign out_valid = v[LATENCY-1];
  assign out_r     = r_q[LATENCY-1];
  assign out_zero  = zero_q[LATENCY-1];
  assign out_par   = par_q[LATENCY-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed vectors, backpressure, mid-op reset and a
// randomized stream checked against a queue-based reference model.
module tb_logic_unit_pipe;

  localparam int LAT  = 2;
  localparam int LAT8 = 1;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_zero, out_par;
  logic [63:0] in_a, in_b, out_r;
  logic [2:0]  in_op;

  logic        in8_valid, in8_ready, out8_valid, out8_ready, out8_zero, out8_par;
  logic [7:0]  in8_a, in8_b, out8_r;
  logic [2:0]  in8_op;

  logic_unit_pipe #(.WIDTH(64), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_r(out_r), .out_zero(out_zero), .out_par(out_par)
  );

  logic_unit_pipe #(.WIDTH(8), .LATENCY(LAT8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in8_valid), .in_ready(in8_ready),
    .in_a(in8_a), .in_b(in8_b), .in_op(in8_op), .out_valid(out8_valid),
    .out_ready(out8_ready), .out_r(out8_r), .out_zero(out8_zero), .out_par(out8_par)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] r;
    logic        z;
    logic        p;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;
  int   cyc     = 0;
  bit   acc     = 0;
  bit   saw_full = 0;

  function automatic exp_t ref_op(logic [63:0] a, logic [63:0] b, logic [2:0] op, int w);
    exp_t e;
    logic [63:0] mask;
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    case (op)
      3'd0: e.r = a & b;
      3'd1: e.r = a | b;
      3'd2: e.r = a ^ b;
      3'd3: e.r = ~(a & b);
      3'd4: e.r = ~(a | b);
      3'd5: e.r = ~(a ^ b);
      3'd6: e.r = ~a;
      default: e.r = a;
    endcase
    e.r = e.r & mask;
    e.z = (e.r == 64'd0);
    e.p = ($countones(e.r) % 2) == 1;
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the 64-bit DUT: scoreboard at the negedge, then the edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    cyc++;
    acc = 0;
    if (rst) begin
      chk("rst_in_ready", 64'(in_ready), 64'd0);
    end else begin
      chk("in_ready", 64'(in_ready), 64'((q.size() < LAT) || out_ready));
      if (!in_ready) saw_full = 1;
      if (out_valid) begin
        chk("out_has_pending", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          chk("out_r", out_r, q[0].r);
          chk("out_zero", 64'(out_zero), 64'(q[0].z));
          chk("out_par", 64'(out_par), 64'(q[0].p));
          if (out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) begin
        e = ref_op(in_a, in_b, in_op, 64);
        q.push_back(e);
        acc = 1;
      end
    end
    @(posedge clk);
    if (rst) q.delete();
    #1;
  endtask

  task automatic drain();
    in_valid  = 0;
    out_ready = 1;
    for (int i = 0; i < 20 && q.size() != 0; i++) cycle();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic direct(logic [63:0] a, logic [63:0] b, logic [2:0] op,
                        logic [63:0] er, logic ez, logic ep, string tag);
    in_a = a; in_b = b; in_op = op;
    in_valid = 1; out_ready = 0;
    cycle();
    chk({tag, "_accepted"}, 64'(acc), 64'd1);
    in_valid = 0;
    if (LAT > 1) chk({tag, "_early"}, 64'(out_valid), 64'd0);
    repeat (LAT - 1) cycle();
    chk({tag, "_valid_at_lat"}, 64'(out_valid), 64'd1);
    chk({tag, "_r"}, out_r, er);
    chk({tag, "_zero"}, 64'(out_zero), 64'(ez));
    chk({tag, "_par"}, 64'(out_par), 64'(ep));
    out_ready = 1;
    cycle();
  endtask

  task automatic run8(logic [7:0] a, logic [7:0] b, logic [2:0] op,
                      logic [7:0] er, logic ez, logic ep, string tag);
    in8_a = a; in8_b = b; in8_op = op;
    in8_valid = 1; out8_ready = 0;
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(in8_ready), 64'd1);
    @(posedge clk); #1;
    in8_valid = 0;
    repeat (LAT8 - 1) begin @(posedge clk); #1; end
    chk({tag, "_valid"}, 64'(out8_valid), 64'd1);
    chk({tag, "_r"}, 64'(out8_r), 64'(er));
    chk({tag, "_zero"}, 64'(out8_zero), 64'(ez));
    chk({tag, "_par"}, 64'(out8_par), 64'(ep));
    out8_ready = 1;
    @(posedge clk); #1;
    chk({tag, "_gone"}, 64'(out8_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout n_out=%0d queued=%0d", n_out, q.size());
    $fatal(1, "simulation time limit");
  end

  initial begin
    exp_t e8;
    logic [7:0] ra, rb;
    logic [2:0] rop;
    bit hold;
    int n_before;

    rst = 1; in_valid = 0; out_ready = 0; in_a = '0; in_b = '0; in_op = '0;
    in8_valid = 0; out8_ready = 0; in8_a = '0; in8_b = '0; in8_op = '0;
    cycle();
    cycle();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_r", out_r, 64'd0);
    chk("reset_out_zero", 64'(out_zero), 64'd0);
    chk("reset_out_par", 64'(out_par), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    rst = 0;

    // First cycle out of reset must accept.
    direct(64'd1034024, 64'd1232345, 3'd2, 64'h1D0AF1, 1'b0, 1'b1, "xor");
    direct(64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 3'd2, 64'd0, 1'b1, 1'b0, "xor_zero");
    direct(64'd0, 64'h1234, 3'd6, {64{1'b1}}, 1'b0, 1'b0, "nota_ones");
    drain();

    run8(8'hA5, 8'h0F, 3'd0, 8'h05, 1'b0, 1'b0, "w8_and");
    run8(8'hFF, 8'hFF, 3'd3, 8'h00, 1'b1, 1'b0, "w8_nand");
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 3'(i);
      e8 = ref_op({56'd0, ra}, {56'd0, rb}, rop, 8);
      run8(ra, rb, rop, e8.r[7:0], e8.z, e8.p, "w8_rand");
    end

    // Backpressure: six back-to-back ops, output stalled in cycles 3..6.
    n_before = n_out;
    saw_full = 0;
    hold = 0;
    begin
      int sent;
      sent = 0;
      for (int i = 0; i < 16; i++) begin
        if (!hold) begin
          in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_op = 3'($urandom);
        end
        in_valid  = (sent < 6);
        out_ready = !(i >= 3 && i <= 6);
        cycle();
        if (acc) sent++;
        hold = in_valid && !acc;
      end
      chk("bp_sent", 64'(sent), 64'd6);
    end
    drain();
    chk("bp_delivered", 64'(n_out - n_before), 64'd6);
    chk("bp_in_ready_dropped", 64'(saw_full), 64'd1);

    // Reset with two ops in flight: they must never come out.
    out_ready = 0;
    in_valid  = 1;
    in_a = 64'h55; in_b = 64'hF0; in_op = 3'd1;
    cycle();
    in_a = 64'h77; in_b = 64'h11; in_op = 3'd0;
    cycle();
    in_valid = 0;
    chk("rst_mid_inflight", 64'(q.size()), 64'd2);
    rst = 1;
    cycle();
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_out_r", out_r, 64'd0);
    chk("rst_mid_out_zero", 64'(out_zero), 64'd0);
    chk("rst_mid_out_par", 64'(out_par), 64'd0);
    rst = 0;
    out_ready = 1;
    n_before = n_out;
    repeat (6) cycle();
    chk("rst_mid_no_ghost", 64'(n_out - n_before), 64'd0);

    // Randomized stream with random valid/ready; upstream holds while stalled.
    hold = 0;
    for (int i = 0; i < 10000; i++) begin
      if (!hold) begin
        in_a  = {$urandom, $urandom};
        in_b  = ($urandom_range(0, 7) == 0) ? in_a : {$urandom, $urandom};
        in_op = 3'($urandom);
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
      hold = in_valid && !acc;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
